// File: rtl/booth_ctrl.sv
// booth_ctrl: sequencing controller for a radix-2 Booth multiplier datapath.
//
// Accepts a host request while idle, then alternates EVAL/SHIFT for N_BIT
// iterations. In EVAL it decodes the Booth pair {Q0, Q-1} into an add or
// subtract strobe; in SHIFT it requests an arithmetic shift. The final
// 2*N_BIT product is captured into a register and offered under a
// valid/ready handshake.
//
// Ports
//   Clock      in   system clock, rising edge
//   Reset      in   synchronous active-high reset, dominant over all inputs
//   Request    in   host start, sampled only in IDLE
//   Q_out      in   datapath Booth pair on [1:0]; bit 2 is not used
//   Result     in   live datapath product
//   Done       out  high only in IDLE; also gates the datapath operand load
//   add_s      out  add multiplicand to upper half
//   sub_s      out  subtract multiplicand from upper half
//   ashift_s   out  arithmetic shift right of the whole datapath register
//   Res_data   out  registered signed product
//   Res_valid  out  Res_data valid, held until accepted
//   Res_ready  in   consumer accepts when Res_valid & Res_ready
module booth_ctrl #(
  parameter int unsigned N_BIT = 8
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               Request,
  input  logic [2:0]         Q_out,
  input  logic [2*N_BIT-1:0] Result,
  output logic               Done,
  output logic               add_s,
  output logic               sub_s,
  output logic               ashift_s,
  output logic [2*N_BIT-1:0] Res_data,
  output logic               Res_valid,
  input  logic               Res_ready
);

  localparam int unsigned CntW = (N_BIT > 2) ? $clog2(N_BIT) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(N_BIT - 1);

  typedef enum logic [2:0] {
    StIdle,
    StEval,
    StShift,
    StCapture,
    StResult
  } state_e;

  state_e             state_q, state_d;
  logic [CntW-1:0]    count_q, count_d;
  logic [2*N_BIT-1:0] res_data_q, res_data_d;
  logic               res_valid_q, res_valid_d;

  // Q_out[2] is carried by the datapath interface but has no meaning here.
  logic unused_q_out;
  assign unused_q_out = Q_out[2];

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q     <= StIdle;
      count_q     <= '0;
      res_data_q  <= '0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      res_data_q  <= res_data_d;
      res_valid_q <= res_valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    res_data_d  = res_data_q;
    res_valid_d = res_valid_q;
    Done        = 1'b0;
    add_s       = 1'b0;
    sub_s       = 1'b0;
    ashift_s    = 1'b0;

    unique case (state_q)
      StIdle: begin
        Done = 1'b1;
        if (Request) begin
          state_d = StEval;
          count_d = '0;
        end
      end

      StEval: begin
        // 01: end of a run of ones -> add; 10: start of a run -> subtract.
        unique case (Q_out[1:0])
          2'b01:   add_s = 1'b1;
          2'b10:   sub_s = 1'b1;
          default: ;
        endcase
        state_d = StShift;
      end

      StShift: begin
        ashift_s = 1'b1;
        if (count_q == CntMax) begin
          state_d = StCapture;
        end else begin
          count_d = count_q + 1'b1;
          state_d = StEval;
        end
      end

      StCapture: begin
        // Datapath is quiescent here, so Result is the final product.
        res_data_d  = Result;
        res_valid_d = 1'b1;
        state_d     = StResult;
      end

      StResult: begin
        if (Res_ready) begin
          res_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  assign Res_data  = res_data_q;
  assign Res_valid = res_valid_q;

endmodule
